vga_pixel_fifo: RTL and testbench

- Elastic pixel buffer between grey_to_rgb (producer) and vga_driver (consumer).
- Absorbs the variable latency and bursty output of the edge_filter pipeline, so vga_driver reads at its own raster cadence.
- Write side: one-cycle valid strobes from the processing chain. Read side: vga_driver's ready requests, each answered with one pixel one cycle later.
- Holds reads off until a programmable prime level is reached, then streams. Starvation and overrun are flagged rather than stalling anything.

---
 rtl/vga_pixel_fifo.sv | 106 ++++++++++
 tb/tb_vga_pixel_fifo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fifo.sv
// Elastic pixel buffer between grey_to_rgb and vga_driver: primes to a set level, then streams.
// Optional FIFO_STATS_EN adds saturating drop_count / starve_count outputs.
module vga_pixel_fifo #(
  parameter int DATA_W      = 12,
  parameter int DEPTH       = 1024,
  parameter int PRIME_LEVEL = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        pixel_in,
  input  logic                     in_ready,
  input  logic                     rd_req,
  output logic [DATA_W-1:0]        pixel_out,
  output logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     primed,
  output logic                     overflow,
`ifdef FIFO_STATS_EN
  output logic                     underflow,
  output logic [15:0]              drop_count,
  output logic [15:0]              starve_count
`else
  output logic                     underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);

  localparam logic [0:0] ST_PRIME  = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [0:0]        state;

  logic rd_acc, pop, push, drop, starve;

  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);

  // A read is only honoured once streaming; a pop on a full FIFO frees the slot
  // for a same-cycle write, so that write is accepted rather than dropped.
  assign rd_acc = (state == ST_STREAM) && rd_req;
  assign pop    = rd_acc && !empty;
  assign starve = rd_acc && empty;
  assign push   = in_ready && (!full || pop);
  assign drop   = in_ready && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pixel_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      state     <= ST_PRIME;
      primed    <= 1'b0;
      pixel_out <= '0;
      out_ready <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // Prime decision looks at the registered level, so STREAM starts one cycle after the threshold.
      if (state == ST_PRIME && level >= PRIME_L) begin
        state  <= ST_STREAM;
        primed <= 1'b1;
      end

      out_ready <= rd_acc;
      if (pop)         pixel_out <= mem[rd_ptr];
      else if (starve) pixel_out <= '0;

      if (drop)   overflow  <= 1'b1;
      if (starve) underflow <= 1'b1;
    end
  end

`ifdef FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count   <= '0;
      starve_count <= '0;
    end else begin
      if (drop && drop_count != 16'hFFFF)       drop_count   <= drop_count + 16'd1;
      if (starve && starve_count != 16'hFFFF)   starve_count <= starve_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Directed bench for vga_pixel_fifo at DEPTH=16, PRIME_LEVEL=8.
module tb_vga_pixel_fifo;
  localparam int DW = 12;
  localparam int DEPTH = 16;
  localparam int PRIME = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pixel_in;
  logic          in_ready, rd_req;
  logic [DW-1:0] pixel_out;
  logic          out_ready, full, empty, primed, overflow, underflow;
  logic [4:0]    level;
`ifdef FIFO_STATS_EN
  logic [15:0]   drop_count, starve_count;
`endif

  int tests = 0;
  int fails = 0;

  vga_pixel_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_ready(in_ready), .rd_req(rd_req),
    .pixel_out(pixel_out), .out_ready(out_ready), .level(level), .full(full),
    .empty(empty), .primed(primed), .overflow(overflow),
`ifdef FIFO_STATS_EN
    .underflow(underflow), .drop_count(drop_count), .starve_count(starve_count)
`else
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_ready = 1'b0; rd_req = 1'b0; pixel_in = '0;
    tick(); tick();
    rst = 1'b0;
    tests++; if (level !== 5'd0)      begin fails++; $display("FAIL reset_level got %0d want 0", level); end
    tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL reset_flags empty=%b full=%b want 1/0", empty, full); end
    tests++; if (primed !== 1'b0 || out_ready !== 1'b0) begin fails++; $display("FAIL reset_ctl primed=%b out_ready=%b want 0/0", primed, out_ready); end
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL reset_sticky ovf=%b unf=%b want 0/0", overflow, underflow); end
    tests++; if (pixel_out !== 12'h000) begin fails++; $display("FAIL reset_pixel got %h want 000", pixel_out); end
  endtask

  task automatic test_prime();
    for (int i = 1; i <= 7; i++) begin
      in_ready = 1'b1; rd_req = 1'b1; pixel_in = DW'(i);
      tick();
      tests++; if (out_ready !== 1'b0) begin fails++; $display("FAIL prime_no_read[%0d] out_ready got %b want 0", i, out_ready); end
    end
    tests++; if (level !== 5'd7 || primed !== 1'b0) begin fails++; $display("FAIL prime_level7 level=%0d primed=%b want 7/0", level, primed); end
    in_ready = 1'b1; rd_req = 1'b0; pixel_in = 12'h008;
    tick();
    in_ready = 1'b0;
    tests++; if (level !== 5'd8 || primed !== 1'b0) begin fails++; $display("FAIL prime_level8 level=%0d primed=%b want 8/0", level, primed); end
    tick();
    tests++; if (primed !== 1'b1) begin fails++; $display("FAIL prime_enter primed got %b want 1", primed); end
  endtask

  task automatic test_stream_order();
    for (int i = 1; i <= 3; i++) begin
      rd_req = 1'b1;
      tick();
      tests++; if (out_ready !== 1'b1 || pixel_out !== DW'(i)) begin fails++; $display("FAIL stream_rd[%0d] out_ready=%b pixel=%h want 1/%h", i, out_ready, pixel_out, DW'(i)); end
    end
    rd_req = 1'b0;
    tick();
    tests++; if (out_ready !== 1'b0 || pixel_out !== 12'h003) begin fails++; $display("FAIL stream_hold out_ready=%b pixel=%h want 0/003", out_ready, pixel_out); end
    tests++; if (level !== 5'd5) begin fails++; $display("FAIL stream_level got %0d want 5", level); end
  endtask

  task automatic test_overflow();
    for (int i = 9; i <= 19; i++) begin
      in_ready = 1'b1; pixel_in = DW'(i);
      tick();
    end
    tests++; if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin fails++; $display("FAIL ovf_fill level=%0d full=%b ovf=%b want 16/1/0", level, full, overflow); end
    pixel_in = 12'hABC;
    tick(); tick();
    in_ready = 1'b0;
    tests++; if (level !== 5'd16 || overflow !== 1'b1) begin fails++; $display("FAIL ovf_drop level=%0d ovf=%b want 16/1", level, overflow); end
`ifdef FIFO_STATS_EN
    tests++; if (drop_count !== 16'd2) begin fails++; $display("FAIL ovf_drop_count got %0d want 2", drop_count); end
`endif
  endtask

  task automatic test_full_rw();
    logic [DW-1:0] exp;
    in_ready = 1'b1; rd_req = 1'b1; pixel_in = 12'h5A5;
    tick();
    in_ready = 1'b0;
    tests++; if (out_ready !== 1'b1 || pixel_out !== 12'h004) begin fails++; $display("FAIL full_rw_rd out_ready=%b pixel=%h want 1/004", out_ready, pixel_out); end
    tests++; if (level !== 5'd16 || overflow !== 1'b1) begin fails++; $display("FAIL full_rw_level level=%0d ovf=%b want 16/1", level, overflow); end
`ifdef FIFO_STATS_EN
    tests++; if (drop_count !== 16'd2) begin fails++; $display("FAIL full_rw_drop_count got %0d want 2", drop_count); end
`endif
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? DW'(i + 5) : 12'h5A5;
      tick();
      tests++; if (out_ready !== 1'b1 || pixel_out !== exp) begin fails++; $display("FAIL full_drain[%0d] out_ready=%b pixel=%h want 1/%h", i, out_ready, pixel_out, exp); end
    end
    rd_req = 1'b0;
    tests++; if (level !== 5'd0 || empty !== 1'b1 || underflow !== 1'b0) begin fails++; $display("FAIL full_drain_end level=%0d empty=%b unf=%b want 0/1/0", level, empty, underflow); end
  endtask

  task automatic test_underflow();
    rd_req = 1'b1;
    tick();
    tests++; if (out_ready !== 1'b1 || pixel_out !== 12'h000) begin fails++; $display("FAIL unf_rd out_ready=%b pixel=%h want 1/000", out_ready, pixel_out); end
    tests++; if (underflow !== 1'b1 || primed !== 1'b1) begin fails++; $display("FAIL unf_flag unf=%b primed=%b want 1/1", underflow, primed); end
    in_ready = 1'b1; pixel_in = 12'h777;
    tick();
    in_ready = 1'b0; rd_req = 1'b0;
    tests++; if (out_ready !== 1'b1 || pixel_out !== 12'h000 || level !== 5'd1) begin fails++; $display("FAIL unf_wr out_ready=%b pixel=%h level=%0d want 1/000/1", out_ready, pixel_out, level); end
`ifdef FIFO_STATS_EN
    tests++; if (starve_count !== 16'd2) begin fails++; $display("FAIL unf_starve_count got %0d want 2", starve_count); end
`endif
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tests++; if (out_ready !== 1'b1 || pixel_out !== 12'h777 || level !== 5'd0) begin fails++; $display("FAIL unf_recover pixel=%h level=%0d want 777/0", pixel_out, level); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      in_ready = 1'b1; pixel_in = DW'(12'h100 + i);
      tick();
    end
    tests++; if (level !== 5'd5) begin fails++; $display("FAIL mid_pre level got %0d want 5", level); end
    rst = 1'b1; rd_req = 1'b1;
    tick();
    rst = 1'b0; in_ready = 1'b0;
    tests++; if (level !== 5'd0 || primed !== 1'b0 || out_ready !== 1'b0) begin fails++; $display("FAIL mid_rst level=%0d primed=%b out_ready=%b want 0/0/0", level, primed, out_ready); end
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0 || pixel_out !== 12'h000) begin fails++; $display("FAIL mid_rst_flags ovf=%b unf=%b pixel=%h want 0/0/000", overflow, underflow, pixel_out); end
`ifdef FIFO_STATS_EN
    tests++; if (drop_count !== 16'd0 || starve_count !== 16'd0) begin fails++; $display("FAIL mid_rst_counts drop=%0d starve=%0d want 0/0", drop_count, starve_count); end
`endif
    for (int i = 0; i < 8; i++) begin
      in_ready = 1'b1; pixel_in = DW'(12'h200 + i);
      tick();
      tests++; if (out_ready !== 1'b0) begin fails++; $display("FAIL mid_reprime[%0d] out_ready got %b want 0", i, out_ready); end
    end
    in_ready = 1'b0;
    tick();
    tick();
    tests++; if (out_ready !== 1'b1 || pixel_out !== 12'h200 || primed !== 1'b1) begin fails++; $display("FAIL mid_restream out_ready=%b pixel=%h primed=%b want 1/200/1", out_ready, pixel_out, primed); end
    rd_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prime();
    test_stream_order();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
